// File: rtl/l1_snoop_responder_pkg.sv
// Shared L1 snoop definitions: bus opcodes, MSI line state, cacheline layout,
// address geometry and the responder FSM encoding.
package l1_snoop_responder_pkg;

  localparam int ADDR_BITS     = 32;
  localparam int OFFSET_BITS   = 4;
  localparam int L1_INDEX_BITS = 6;
  localparam int LINE_ADDR_W   = ADDR_BITS - OFFSET_BITS;
  localparam int L1_TAG_BITS   = LINE_ADDR_W - L1_INDEX_BITS;
  localparam int L1_LINE_BITS  = 8 << OFFSET_BITS;

  typedef enum logic [1:0] {
    BUS_RD   = 2'd0,
    BUS_RDX  = 2'd1,
    BUS_UPGR = 2'd2,
    BUS_RSVD = 2'd3
  } bus_op_t;

  typedef enum logic [1:0] {
    ST_I = 2'd0,
    ST_S = 2'd1,
    ST_M = 2'd2
  } l1_state_t;

  typedef struct packed {
    l1_state_t               state;
    logic [L1_TAG_BITS-1:0]  tag;
    logic [L1_LINE_BITS-1:0] data;
  } l1_cacheline_t;

  typedef enum logic [1:0] {
    SN_IDLE   = 2'd0,
    SN_LOOKUP = 2'd1,
    SN_RESP   = 2'd2
  } snoop_fsm_t;

endpackage

// File: rtl/l1_snoop_responder_msi_snoop_next.sv
// msi_snoop_next: pure combinational MSI snoop transition table.
// Given the current line state, bus op, hit and self-snoop flags it yields the
// downgraded state, whether the array must be written, and the bus response.
module msi_snoop_next
  import l1_snoop_responder_pkg::*;
(
  input  l1_state_t i_state,
  input  bus_op_t   i_op,
  input  logic      i_hit,
  input  logic      i_self,
  output l1_state_t o_next_state,
  output logic      o_write_en,
  output logic      o_shared,
  output logic      o_flush,
  output logic      o_err
);

  // Transition table; misses and self-snoops leave the line untouched.
  always_comb begin
    o_next_state = i_state;
    o_write_en   = 1'b0;
    o_shared     = 1'b0;
    o_flush      = 1'b0;
    o_err        = 1'b0;
    if (i_hit && !i_self) begin
      case (i_state)
        ST_M: begin
          o_shared   = 1'b1;
          o_flush    = 1'b1;
          o_write_en = 1'b1;
          case (i_op)
            BUS_RD:  o_next_state = ST_S;
            BUS_RDX: o_next_state = ST_I;
            default: begin
              // Upgrade (or reserved op) against a Modified line is illegal.
              o_next_state = ST_I;
              o_err        = 1'b1;
            end
          endcase
        end
        ST_S: begin
          o_shared = 1'b1;
          if (i_op == BUS_RDX || i_op == BUS_UPGR) begin
            o_next_state = ST_I;
            o_write_en   = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/l1_snoop_responder.sv
// l1_snoop_responder: per-core MSI snoop agent. Accepts one bus request,
// looks the line up through the L1 snoop port for one cycle, writes back the
// downgraded line, then holds a shared/flush response until consumed.
// Optional counters built when SNOOP_STATS_EN is defined.
module l1_snoop_responder
  import l1_snoop_responder_pkg::*;
#(
  parameter int CORE_ID   = 0,
  parameter int NUM_CORES = 4,
  parameter int SRC_W     = $clog2(NUM_CORES)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    i_bus_req_valid,
  output logic                    o_bus_req_ready,
  input  bus_op_t                 i_bus_req_type,
  input  logic [LINE_ADDR_W-1:0]  i_bus_req_addr,
  input  logic [SRC_W-1:0]        i_bus_req_src,
  output logic [LINE_ADDR_W-1:0]  o_addr_snoop,
  input  l1_cacheline_t           i_cacheline_snoop_out,
  output l1_cacheline_t           o_cacheline_snoop_in,
  output logic                    o_snoop_valid,
  output logic                    o_resp_valid,
  input  logic                    i_resp_ready,
  output logic                    o_resp_shared,
  output logic                    o_resp_flush,
  output logic [L1_LINE_BITS-1:0] o_resp_data,
`ifdef SNOOP_STATS_EN
  output logic [15:0]             o_stat_hits,
  output logic [15:0]             o_stat_flushes,
  output logic [15:0]             o_stat_invals,
`endif
  output logic                    o_proto_err
);

  snoop_fsm_t               r_state, w_next;
  bus_op_t                  r_type;
  logic [LINE_ADDR_W-1:0]   r_addr;
  logic [SRC_W-1:0]         r_src;
  logic                     r_shared, r_flush;
  logic [L1_LINE_BITS-1:0]  r_data;

  logic                     w_hit, w_self, w_wr_en, w_shared, w_flush, w_err;
  l1_state_t                w_next_st;
  logic                     w_accept;

  assign w_self   = (r_src == SRC_W'(CORE_ID));
  assign w_hit    = (i_cacheline_snoop_out.state != ST_I) &&
                    (i_cacheline_snoop_out.tag == r_addr[LINE_ADDR_W-1:L1_INDEX_BITS]);
  assign w_accept = (r_state == SN_IDLE) && i_bus_req_valid;

  msi_snoop_next u_next (
    .i_state      (i_cacheline_snoop_out.state),
    .i_op         (r_type),
    .i_hit        (w_hit),
    .i_self       (w_self),
    .o_next_state (w_next_st),
    .o_write_en   (w_wr_en),
    .o_shared     (w_shared),
    .o_flush      (w_flush),
    .o_err        (w_err)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= SN_IDLE;
    else          r_state <= w_next;
  end

  // Next state and combinational port outputs; snoop port only active in LOOKUP.
  always_comb begin
    w_next               = r_state;
    o_bus_req_ready      = 1'b0;
    o_addr_snoop         = '0;
    o_cacheline_snoop_in = '0;
    o_snoop_valid        = 1'b0;
    o_proto_err          = 1'b0;
    o_resp_valid         = 1'b0;
    case (r_state)
      SN_IDLE: begin
        // Gate with reset so ready is low while reset is held.
        o_bus_req_ready = reset_n;
        if (i_bus_req_valid) w_next = SN_LOOKUP;
      end
      SN_LOOKUP: begin
        o_addr_snoop               = r_addr;
        o_cacheline_snoop_in       = i_cacheline_snoop_out;
        o_cacheline_snoop_in.state = w_next_st;
        o_snoop_valid              = w_wr_en;
        o_proto_err                = w_err;
        w_next                     = SN_RESP;
      end
      SN_RESP: begin
        o_resp_valid = 1'b1;
        if (i_resp_ready) w_next = SN_IDLE;
      end
      default: w_next = SN_IDLE;
    endcase
  end

  // Request capture on handshake.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_type <= BUS_RD;
      r_addr <= '0;
      r_src  <= '0;
    end else if (w_accept) begin
      r_type <= i_bus_req_type;
      r_addr <= i_bus_req_addr;
      r_src  <= i_bus_req_src;
    end
  end

  // Response capture at the end of LOOKUP from the pre-write line image.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_shared <= 1'b0;
      r_flush  <= 1'b0;
      r_data   <= '0;
    end else if (r_state == SN_LOOKUP) begin
      r_shared <= w_shared;
      r_flush  <= w_flush;
      r_data   <= w_flush ? i_cacheline_snoop_out.data : '0;
    end
  end

  assign o_resp_shared = r_shared;
  assign o_resp_flush  = r_flush;
  assign o_resp_data   = r_data;

`ifdef SNOOP_STATS_EN
  logic [15:0] r_hits, r_flushes, r_invals;
  logic        w_lookup, w_inval;

  assign w_lookup = (r_state == SN_LOOKUP);
  assign w_inval  = w_wr_en && (w_next_st == ST_I);

  // Saturating event counters, sampled at the end of LOOKUP.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hits    <= '0;
      r_flushes <= '0;
      r_invals  <= '0;
    end else if (w_lookup) begin
      if (w_shared && r_hits    != 16'hFFFF) r_hits    <= r_hits + 16'd1;
      if (w_flush  && r_flushes != 16'hFFFF) r_flushes <= r_flushes + 16'd1;
      if (w_inval  && r_invals  != 16'hFFFF) r_invals  <= r_invals + 16'd1;
    end
  end

  assign o_stat_hits    = r_hits;
  assign o_stat_flushes = r_flushes;
  assign o_stat_invals  = r_invals;
`endif

endmodule

// File: tb/tb_l1_snoop_responder.sv
// Directed bench for l1_snoop_responder with a small L1 array model behind
// the snoop port. Table of single-request vectors plus stall/reset sequences.
module tb_l1_snoop_responder;
  import l1_snoop_responder_pkg::*;

  localparam logic [L1_LINE_BITS-1:0] DEAD = {4{32'hDEADBEEF}};

  logic                    clk = 1'b0;
  logic                    reset_n = 1'b0;
  logic                    bus_req_valid = 1'b0;
  logic                    bus_req_ready;
  bus_op_t                 bus_req_type = BUS_RD;
  logic [LINE_ADDR_W-1:0]  bus_req_addr = '0;
  logic [1:0]              bus_req_src = '0;
  logic [LINE_ADDR_W-1:0]  addr_snoop;
  l1_cacheline_t           cl_out, cl_in;
  logic                    snoop_valid;
  logic                    resp_valid;
  logic                    resp_ready = 1'b0;
  logic                    resp_shared, resp_flush, proto_err;
  logic [L1_LINE_BITS-1:0] resp_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  l1_snoop_responder #(.CORE_ID(0), .NUM_CORES(4)) dut (
    .clk                   (clk),
    .reset_n               (reset_n),
    .i_bus_req_valid       (bus_req_valid),
    .o_bus_req_ready       (bus_req_ready),
    .i_bus_req_type        (bus_req_type),
    .i_bus_req_addr        (bus_req_addr),
    .i_bus_req_src         (bus_req_src),
    .o_addr_snoop          (addr_snoop),
    .i_cacheline_snoop_out (cl_out),
    .o_cacheline_snoop_in  (cl_in),
    .o_snoop_valid         (snoop_valid),
    .o_resp_valid          (resp_valid),
    .i_resp_ready          (resp_ready),
    .o_resp_shared         (resp_shared),
    .o_resp_flush          (resp_flush),
    .o_resp_data           (resp_data),
    .o_proto_err           (proto_err)
  );

  // L1 array model: combinational read, snoop write lands on the clock edge.
  l1_cacheline_t             mem [64];
  logic                      pl_en = 1'b0;
  logic [L1_INDEX_BITS-1:0]  pl_idx = '0;
  l1_cacheline_t             pl_line = '0;

  assign cl_out = mem[addr_snoop[L1_INDEX_BITS-1:0]];

  always @(posedge clk) begin
    if (pl_en)            mem[pl_idx] <= pl_line;
    else if (snoop_valid) mem[addr_snoop[L1_INDEX_BITS-1:0]] <= cl_in;
  end

  typedef struct {
    bus_op_t                 op;
    logic [LINE_ADDR_W-1:0]  addr;
    logic [1:0]              src;
    l1_cacheline_t           init;
    logic                    exp_sv;
    l1_state_t               exp_st;
    logic                    exp_sh;
    logic                    exp_fl;
    logic                    exp_err;
    logic [L1_LINE_BITS-1:0] exp_data;
  } vec_t;

  function automatic vec_t mk(bus_op_t op, logic [L1_TAG_BITS-1:0] rtag,
                              logic [L1_INDEX_BITS-1:0] idx, logic [1:0] src,
                              l1_state_t ist, logic [L1_TAG_BITS-1:0] itag,
                              logic sv, l1_state_t est, logic sh, logic fl, logic err);
    vec_t v;
    v.op         = op;
    v.addr       = {rtag, idx};
    v.src        = src;
    v.init.state = ist;
    v.init.tag   = itag;
    v.init.data  = DEAD ^ L1_LINE_BITS'(idx);
    v.exp_sv     = sv;
    v.exp_st     = est;
    v.exp_sh     = sh;
    v.exp_fl     = fl;
    v.exp_err    = err;
    v.exp_data   = fl ? v.init.data : '0;
    return v;
  endfunction

  task automatic chk(input string name, input logic [L1_LINE_BITS-1:0] act,
                     input logic [L1_LINE_BITS-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [L1_INDEX_BITS-1:0] idx, input l1_cacheline_t ln);
    @(negedge clk);
    pl_en = 1'b1; pl_idx = idx; pl_line = ln;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Drive a request at a negedge; returns at the negedge inside LOOKUP.
  task automatic issue(input bus_op_t op, input logic [LINE_ADDR_W-1:0] addr,
                       input logic [1:0] src);
    chk("ready_idle", bus_req_ready, 1);
    bus_req_valid = 1'b1; bus_req_type = op; bus_req_addr = addr; bus_req_src = src;
    @(posedge clk);
    @(negedge clk);
    bus_req_valid = 1'b0;
  endtask

  vec_t vecs [12];

  initial begin
    vecs[0]  = mk(BUS_RD,   22'h12, 6'd3, 2'd1, ST_M, 22'h12, 1, ST_S, 1, 1, 0);
    vecs[1]  = mk(BUS_RDX,  22'h12, 6'd3, 2'd2, ST_S, 22'h12, 1, ST_I, 1, 0, 0);
    vecs[2]  = mk(BUS_RD,   22'h13, 6'd3, 2'd1, ST_M, 22'h12, 0, ST_M, 0, 0, 0);
    vecs[3]  = mk(BUS_RDX,  22'h12, 6'd3, 2'd0, ST_M, 22'h12, 0, ST_M, 0, 0, 0);
    vecs[4]  = mk(BUS_UPGR, 22'h12, 6'd3, 2'd1, ST_M, 22'h12, 1, ST_I, 1, 1, 1);
    vecs[5]  = mk(BUS_RD,   22'h12, 6'd3, 2'd3, ST_S, 22'h12, 0, ST_S, 1, 0, 0);
    vecs[6]  = mk(BUS_RSVD, 22'h12, 6'd3, 2'd1, ST_S, 22'h12, 0, ST_S, 1, 0, 0);
    vecs[7]  = mk(BUS_RD,   22'h12, 6'd3, 2'd1, ST_I, 22'h12, 0, ST_I, 0, 0, 0);
    vecs[8]  = mk(BUS_RSVD, 22'h12, 6'd3, 2'd2, ST_M, 22'h12, 1, ST_I, 1, 1, 1);
    vecs[9]  = mk(BUS_RDX,  22'h12, 6'd3, 2'd3, ST_M, 22'h12, 1, ST_I, 1, 1, 0);
    vecs[10] = mk(BUS_UPGR, 22'h12, 6'd3, 2'd1, ST_S, 22'h12, 1, ST_I, 1, 0, 0);
    vecs[11] = mk(BUS_RD,   22'h2A, 6'd5, 2'd2, ST_M, 22'h2A, 1, ST_S, 1, 1, 0);

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_ready", bus_req_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_snoop_valid", snoop_valid, 0);
    chk("rst_proto_err", proto_err, 0);
    reset_n = 1'b1;
    #1;
    chk("post_rst_ready", bus_req_ready, 1);

    for (int i = 0; i < 12; i++) begin
      preload(vecs[i].addr[L1_INDEX_BITS-1:0], vecs[i].init);
      issue(vecs[i].op, vecs[i].addr, vecs[i].src);
      // LOOKUP cycle
      chk($sformatf("v%0d_snoop_valid", i), snoop_valid, vecs[i].exp_sv);
      chk($sformatf("v%0d_proto_err", i), proto_err, vecs[i].exp_err);
      chk($sformatf("v%0d_ready_lookup", i), bus_req_ready, 0);
      chk($sformatf("v%0d_resp_valid_lookup", i), resp_valid, 0);
      if (vecs[i].exp_sv) begin
        chk($sformatf("v%0d_wb_state", i), cl_in.state, vecs[i].exp_st);
        chk($sformatf("v%0d_wb_data", i), cl_in.data, vecs[i].init.data);
      end
      @(negedge clk);
      // RESP cycle
      chk($sformatf("v%0d_resp_valid", i), resp_valid, 1);
      chk($sformatf("v%0d_shared", i), resp_shared, vecs[i].exp_sh);
      chk($sformatf("v%0d_flush", i), resp_flush, vecs[i].exp_fl);
      chk($sformatf("v%0d_data", i), resp_data, vecs[i].exp_data);
      chk($sformatf("v%0d_proto_err_resp", i), proto_err, 0);
      chk($sformatf("v%0d_l1_state", i), mem[vecs[i].addr[L1_INDEX_BITS-1:0]].state,
          vecs[i].exp_st);
      chk($sformatf("v%0d_l1_tag", i), mem[vecs[i].addr[L1_INDEX_BITS-1:0]].tag,
          vecs[i].init.tag);
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      chk($sformatf("v%0d_resp_done", i), resp_valid, 0);
      chk($sformatf("v%0d_ready_back", i), bus_req_ready, 1);
    end

    // Back-pressure: response held for 5 cycles with resp_ready low.
    preload(6'd3, '{state: ST_M, tag: 22'h12, data: DEAD});
    issue(BUS_RD, {22'h12, 6'd3}, 2'd1);
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("stall%0d_valid", c), resp_valid, 1);
      chk($sformatf("stall%0d_shared", c), resp_shared, 1);
      chk($sformatf("stall%0d_flush", c), resp_flush, 1);
      chk($sformatf("stall%0d_data", c), resp_data, DEAD);
      chk($sformatf("stall%0d_ready", c), bus_req_ready, 0);
      chk($sformatf("stall%0d_snoop_valid", c), snoop_valid, 0);
      @(negedge clk);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("stall_done", resp_valid, 0);

    // Reset asserted during LOOKUP: no write, no response.
    preload(6'd3, '{state: ST_M, tag: 22'h12, data: DEAD});
    issue(BUS_RDX, {22'h12, 6'd3}, 2'd1);
    chk("midrst_lookup_sv", snoop_valid, 1);
    reset_n = 1'b0;
    #1;
    chk("midrst_ready_low", bus_req_ready, 0);
    chk("midrst_sv_low", snoop_valid, 0);
    chk("midrst_resp_low", resp_valid, 0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("midrst_l1_state", mem[3].state, ST_M);
    chk("midrst_ready_after", bus_req_ready, 1);
    @(negedge clk);
    chk("midrst_no_resp", resp_valid, 0);
    chk("midrst_ready_idle", bus_req_ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
